bin2bcd_seq: RTL

//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bin2bcd_seq_pkg.sv | 15 +
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/bin2bcd_seq.sv | 96 +++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encodings and the double-dabble adjust constants.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int         BCD_DIGITS     = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble nibble correction: any digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= BCD_ADJ_THRESH) ? nibble + BCD_ADJ_ADD : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one binary bit per clock.
// start is taken in IDLE, WIDTH shift cycles follow, and the result is
// published to the digit registers with a one-cycle done pulse.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4
);

  // Four BCD digits cover at most 9999, so wider inputs cannot be represented.
  if (WIDTH < 1 || WIDTH > 13) begin : g_width_check
    $error("bin2bcd_seq: WIDTH must be in 1..13");
  end

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t                  state;
  logic [WIDTH-1:0]        shreg;
  logic [CW-1:0]           cnt;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [4*BCD_DIGITS-1:0] adj;

  // The top adjusted bit shifts out of the scratch; with inputs below 10000
  // it is always zero, so it is intentionally dropped.
  logic adj_msb_unused;
  assign adj_msb_unused = adj[4*BCD_DIGITS-1];

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .nibble  (bcd[4*g +: 4]),
      .adjusted(adj[4*g +: 4])
    );
  end

  // Control FSM, scratch shift registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      shreg  <= '0;
      cnt    <= '0;
      bcd    <= '0;
      digit1 <= 4'd0;
      digit2 <= 4'd0;
      digit3 <= 4'd0;
      digit4 <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjust first, then shift the next binary bit into the BCD scratch.
          bcd   <= {adj[4*BCD_DIGITS-2:0], shreg[WIDTH-1]};
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= LOAD;
        end
        LOAD: begin
          digit1 <= bcd[3:0];
          digit2 <= bcd[7:4];
          digit3 <= bcd[11:8];
          digit4 <= bcd[15:12];
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
